// File: rtl/fifo_ram_ctrl.sv
// Pointer/flag controller for a single-clock FIFO built on an external
// combinational-read dual-port RAM. This block owns every pointer and all flow control.
module fifo_ram_ctrl #(
  parameter int ADDR_SIZE     = 4,
  parameter int DATA_SIZE     = 8,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 ram_wr_en,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [DATA_SIZE-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_SIZE-1:0] ram_rd_data
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_THRESH);

  logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]        count_reg, count_next;
  logic                 full_reg, full_next;
  logic                 empty_reg, empty_next;
  logic                 afull_reg, afull_next;
  logic                 aempty_reg, aempty_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;
  logic [DATA_SIZE-1:0] rd_data_reg, rd_data_next;
  logic                 rd_valid_reg;
  logic                 push_ok, pop_ok;

  // Acceptance uses only registered flags, so flags never depend on wr_en/rd_en combinationally.
  always_comb begin
    push_ok = wr_en & ~full_reg & ~reset;
    pop_ok  = rd_en & ~empty_reg & ~reset;
  end

  always_comb begin
    wr_ptr_next    = wr_ptr_reg + PW'(push_ok);
    rd_ptr_next    = rd_ptr_reg + PW'(pop_ok);
    count_next     = count_reg + PW'(push_ok) - PW'(pop_ok);
    full_next      = (wr_ptr_next[ADDR_SIZE-1:0] == rd_ptr_next[ADDR_SIZE-1:0]) &&
                     (wr_ptr_next[ADDR_SIZE] != rd_ptr_next[ADDR_SIZE]);
    empty_next     = (wr_ptr_next == rd_ptr_next);
    afull_next     = (count_next >= AF_LVL);
    aempty_next    = (count_next <= AE_LVL);
    overflow_next  = overflow_reg | (wr_en & full_reg);
    underflow_next = underflow_reg | (rd_en & empty_reg);
    rd_data_next   = pop_ok ? ram_rd_data : rd_data_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      afull_reg     <= afull_next;
      aempty_reg    <= aempty_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      rd_data_reg   <= rd_data_next;
      rd_valid_reg  <= pop_ok;
    end
  end

  // RAM side is a straight decode of the current pointers and acceptance.
  always_comb begin
    ram_wr_en   = push_ok;
    ram_wr_addr = wr_ptr_reg[ADDR_SIZE-1:0];
    ram_wr_data = wr_data;
    ram_rd_en   = pop_ok;
    ram_rd_addr = rd_ptr_reg[ADDR_SIZE-1:0];
  end

  always_comb begin
    rd_data      = rd_data_reg;
    rd_valid     = rd_valid_reg;
    full         = full_reg;
    empty        = empty_reg;
    almost_full  = afull_reg;
    almost_empty = aempty_reg;
    count        = count_reg;
    overflow     = overflow_reg;
    underflow    = underflow_reg;
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Scoreboard bench for fifo_ram_ctrl with a behavioural RAM; stimulus pushes
// expected pops into a queue, a negedge monitor compares each rd_valid pulse.
module tb_fifo_ram_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   m_wr = '0, m_rd = '0;
  bit            m_ovf = 0, m_unf = 0, m_vld = 0;

  fifo_ram_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid actual=%0d expected=none", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("rd_data", int'(rd_data), int'(e));
      end
    end
  end

  task automatic step(input bit rst, input bit we, input logic [DW-1:0] wd, input bit re);
    bit p_ok, q_ok;
    int n;
    @(negedge clk);
    reset = rst; wr_en = we; wr_data = wd; rd_en = re;
    n = model_q.size();
    p_ok = !rst && we && (n != DEPTH);
    q_ok = !rst && re && (n != 0);
    #1;
    chk("ram_wr_en", int'(ram_wr_en), int'(p_ok));
    chk("ram_rd_en", int'(ram_rd_en), int'(q_ok));
    if (p_ok) begin
      chk("ram_wr_addr", int'(ram_wr_addr), int'(m_wr[AW-1:0]));
      chk("ram_wr_data", int'(ram_wr_data), int'(wd));
    end
    if (q_ok) chk("ram_rd_addr", int'(ram_rd_addr), int'(m_rd[AW-1:0]));
    if (rst) begin
      model_q.delete();
      m_wr = '0; m_rd = '0; m_ovf = 0; m_unf = 0; m_vld = 0;
    end else begin
      if (we && n == DEPTH) m_ovf = 1;
      if (re && n == 0) m_unf = 1;
      if (q_ok) begin exp_q.push_back(model_q.pop_front()); m_rd = m_rd + 1'b1; end
      if (p_ok) begin model_q.push_back(wd); m_wr = m_wr + 1'b1; end
      m_vld = q_ok;
    end
    @(posedge clk);
    #1;
    n = model_q.size();
    $display("step rst=%0d we=%0d wd=%0d re=%0d -> count=%0d full=%0d empty=%0d ovf=%0d unf=%0d vld=%0d",
             rst, we, wd, re, count, full, empty, overflow, underflow, rd_valid);
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= 12));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
    chk("rd_valid", int'(rd_valid), int'(m_vld));
  endtask

  task automatic push_n(input int n, input int base, input int mul);
    for (int k = 0; k < n; k++) step(0, 1, DW'(base + k * mul), 0);
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 1);
  endtask

  initial begin
    // Reset and idle
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rd_data_reset", int'(rd_data), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Fill with k*3, overflow, drain, underflow
    push_n(16, 0, 3);
    chk("count_full16", int'(count), 16);
    chk("full_at16", int'(full), 1);
    step(0, 1, 8'd99, 0);
    chk("overflow_set", int'(overflow), 1);
    pop_n(16);
    chk("empty_after_drain", int'(empty), 1);
    step(0, 0, 0, 1);
    chk("underflow_set", int'(underflow), 1);

    // Wrap-around ordering
    step(1, 0, 0, 0);
    push_n(10, 100, 1);
    pop_n(10);
    push_n(12, 150, 1);
    pop_n(12);
    chk("count_after_wrap", int'(count), 0);

    // Simultaneous push/pop at empty, full, and mid-level
    step(1, 0, 0, 0);
    step(0, 1, 8'd7, 1);
    chk("sim_empty_count", int'(count), 1);
    chk("sim_empty_unf", int'(underflow), 1);
    pop_n(1);
    push_n(16, 200, 2);
    step(0, 1, 8'd77, 1);
    chk("sim_full_count", int'(count), 15);
    chk("sim_full_ovf", int'(overflow), 1);
    pop_n(10);
    step(0, 1, 8'd55, 1);
    chk("sim_mid_count", int'(count), 5);

    // Reset dominates simultaneous requests
    push_n(2, 60, 1);
    chk("count_before_reset", int'(count), 7);
    step(1, 1, 8'd33, 1);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_ovf", int'(overflow), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
